// File: rtl/demux8_capture.sv
`default_nettype none
// ============================================================================
// Module   : demux8_capture
// Brief    : Serial-to-parallel capture. One data bit per active-low strobe is
//            steered into bit position `sel` (manual mode) or an internal
//            auto-incrementing position (auto mode) of an 8-bit shadow word.
//            Once all 8 positions are written, the word is presented on a
//            valid/ready port. Partial words are discarded after TIMEOUT idle
//            cycles (TIMEOUT = 0 disables this).
// Options  : define DEMUX8_PARITY_EN to expect a 9th strobe carrying an
//            odd-parity bit over the word; q_perr then flags a bad parity.
// Revision : 1.0 - initial release
// ============================================================================
module demux8_capture #(
  parameter bit AUTO_DEFAULT = 1'b0,
  parameter int TIMEOUT      = 255,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic [2:0] sel,
  input  logic       stb_n,
  input  logic       auto,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       ovr,
  output logic       tout,
  output logic       q_perr
);

`ifdef DEMUX8_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2,
    S_PAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;
`endif

  state_t        r_state;
  logic [7:0]    r_shadow;
  logic [7:0]    r_mask;
  logic [2:0]    r_ptr;
  logic          r_auto;
  logic [TW-1:0] r_idle;
  logic [7:0]    r_q;
  logic          r_q_valid;
  logic          r_ovr;
  logic          r_tout;

  logic          w_stb;
  logic          w_mode;
  logic [2:0]    w_pos;
  logic [7:0]    w_bit;
  logic [7:0]    w_shadow_nx;
  logic [7:0]    w_mask_nx;
  logic          w_full;
  logic [2:0]    w_ptr_inc;
  logic [TW-1:0] w_idle_inc;
  logic          w_tmo;

  // Write-position decode; in IDLE the mode input is used directly since it is
  // being latched in that same cycle, elsewhere the latched mode holds.
  always_comb begin
    w_stb       = ~stb_n;
    w_mode      = (r_state == S_IDLE) ? auto : r_auto;
    w_pos       = w_mode ? r_ptr : sel;
    w_bit       = 8'(1) << w_pos;
    w_shadow_nx = din ? (r_shadow | w_bit) : (r_shadow & ~w_bit);
    w_mask_nx   = r_mask | w_bit;
    w_full      = &w_mask_nx;
    w_ptr_inc   = r_ptr + 3'd1;
    w_idle_inc  = r_idle + TW'(1);
    w_tmo       = (TIMEOUT != 0) && (w_idle_inc == TW'(TIMEOUT));
  end

`ifdef DEMUX8_PARITY_EN
  logic r_q_perr;
`endif

  // Capture FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shadow  <= 8'h00;
      r_mask    <= 8'h00;
      r_ptr     <= 3'd0;
      r_auto    <= AUTO_DEFAULT;
      r_idle    <= '0;
      r_q       <= 8'h00;
      r_q_valid <= 1'b0;
      r_ovr     <= 1'b0;
      r_tout    <= 1'b0;
`ifdef DEMUX8_PARITY_EN
      r_q_perr  <= 1'b0;
`endif
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_auto <= auto;
          r_idle <= '0;
          if (w_stb) begin
            r_shadow <= w_shadow_nx;
            r_mask   <= w_mask_nx;
            if (w_mode) r_ptr <= w_ptr_inc;
            r_state  <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_stb) begin
            r_idle   <= '0;
            r_shadow <= w_shadow_nx;
            if (w_full) begin
              r_mask <= 8'h00;
              r_ptr  <= 3'd0;
`ifdef DEMUX8_PARITY_EN
              r_state <= S_PAR;
`else
              r_q       <= w_shadow_nx;
              r_q_valid <= 1'b1;
              r_state   <= S_HOLD;
`endif
            end else begin
              r_mask <= w_mask_nx;
              if (r_auto) r_ptr <= w_ptr_inc;
            end
          end else if (w_tmo) begin
            r_idle  <= '0;
            r_mask  <= 8'h00;
            r_ptr   <= 3'd0;
            r_tout  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idle <= w_idle_inc;
          end
        end

`ifdef DEMUX8_PARITY_EN
        // Parity strobe: sel is ignored, the bit only qualifies the word.
        S_PAR: begin
          if (w_stb) begin
            r_idle    <= '0;
            r_q       <= r_shadow;
            r_q_perr  <= ~(^r_shadow ^ din);
            r_q_valid <= 1'b1;
            r_state   <= S_HOLD;
          end else if (w_tmo) begin
            r_idle  <= '0;
            r_tout  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
`endif

        S_HOLD: begin
          r_idle <= '0;
          if (q_ready) begin
            r_q_valid <= 1'b0;
            if (w_stb) begin
              // Strobe coinciding with the handshake opens the next word.
              r_shadow <= w_shadow_nx;
              r_mask   <= w_mask_nx;
              if (r_auto) r_ptr <= w_ptr_inc;
              r_state  <= S_FILL;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_stb) begin
            r_ovr <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign ovr     = r_ovr;
  assign tout    = r_tout;
`ifdef DEMUX8_PARITY_EN
  assign q_perr  = r_q_perr;
`else
  assign q_perr  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux8_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_capture
// Brief    : Self-checking bench for demux8_capture (TIMEOUT = 4). Table of
//            whole-word vectors plus hand sequences for overwrite, overrun,
//            timeout, reset and (when DEMUX8_PARITY_EN is defined) parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux8_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [2:0] sel;
  logic       stb_n;
  logic       auto;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       ovr;
  logic       tout;
  logic       q_perr;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {q, q_perr} in completion order.
  logic [8:0] sb_q[$];

  typedef struct packed {
    logic            mode;
    logic [7:0][2:0] sels;  // sels[i] = sel for strobe i
    logic [7:0]      dins;  // dins[i] = din for strobe i
    logic [7:0]      exp;
  } vec_t;

  vec_t vecs[6];

  demux8_capture #(
    .AUTO_DEFAULT(1'b0),
    .TIMEOUT     (4),
    .TW          (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .sel    (sel),
    .stb_n  (stb_n),
    .auto   (auto),
    .q      (q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .ovr    (ovr),
    .tout   (tout),
    .q_perr (q_perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard: compare each accepted word against the queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && q_valid === 1'b1 && q_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got q=0x%0h with no expected word at %0t", q, $time);
      end else begin
        chk("sb_word", {23'd0, q, q_perr}, {23'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic d, input logic [2:0] s);
    din   = d;
    sel   = s;
    stb_n = 1'b0;
    @(posedge clk); #1;
    stb_n = 1'b1;
  endtask

  task automatic set_mode(input logic m);
    auto  = m;
    stb_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Valid must be high exactly in the cycle after the completing strobe.
  task automatic chk_valid_pulse(input string name);
    @(negedge clk);
    chk({name, "_valid_hi"}, {31'd0, q_valid}, 32'd1);
    @(negedge clk);
    chk({name, "_valid_lo"}, {31'd0, q_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_word(input vec_t v, input string name);
    set_mode(v.mode);
    sb_q.push_back({v.exp, 1'b0});
    for (int i = 0; i < 8; i++) strobe(v.dins[i], v.sels[i]);
`ifdef DEMUX8_PARITY_EN
    strobe(~^v.exp, 3'd0);
`endif
    chk_valid_pulse(name);
  endtask

  int   tout_cnt;
  vec_t vt;

  initial begin
    vecs[0] = '{mode: 1'b0, sels: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, dins: 8'h4D, exp: 8'h4D};
    vecs[1] = '{mode: 1'b1, sels: {8{3'd5}},                                   dins: 8'h0F, exp: 8'h0F};
    vecs[2] = '{mode: 1'b1, sels: {8{3'd5}},                                   dins: 8'hFF, exp: 8'hFF};
    vecs[3] = '{mode: 1'b0, sels: {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}, dins: 8'h4D, exp: 8'hB2};
    vecs[4] = '{mode: 1'b0, sels: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, dins: 8'h00, exp: 8'h00};
    vecs[5] = '{mode: 1'b1, sels: {8{3'd2}},                                   dins: 8'hAA, exp: 8'hAA};

    rst_n   = 1'b0;
    din     = 1'b0;
    sel     = 3'd0;
    stb_n   = 1'b1;
    auto    = 1'b0;
    q_ready = 1'b1;
    #1;
    chk("rst_q",       {24'd0, q},       32'h0);
    chk("rst_q_valid", {31'd0, q_valid}, 32'h0);
    chk("rst_ovr",     {31'd0, ovr},     32'h0);
    chk("rst_tout",    {31'd0, tout},    32'h0);
    chk("rst_q_perr",  {31'd0, q_perr},  32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Whole-word vectors (auto entries 1 and 2 run back to back: ptr wraps).
    foreach (vecs[i]) run_word(vecs[i], $sformatf("vec%0d", i));

    // Overwrite: sel 2 written twice, completion only once sel 7 arrives.
    set_mode(1'b0);
    sb_q.push_back({8'hFB, 1'b0});
    strobe(1'b1, 3'd2);
    strobe(1'b0, 3'd2);
    for (int s = 0; s < 7; s++) if (s != 2) strobe(1'b1, 3'(s));
    @(negedge clk);
    chk("ovw_no_early", {31'd0, q_valid}, 32'd0);
    @(posedge clk); #1;
    strobe(1'b1, 3'd7);
`ifdef DEMUX8_PARITY_EN
    strobe(~^8'hFB, 3'd0);
`endif
    chk_valid_pulse("ovw");

    // Overrun while blocked, then handshake coinciding with a new strobe.
    set_mode(1'b0);
    q_ready = 1'b0;
    sb_q.push_back({8'h4D, 1'b0});
    for (int i = 0; i < 8; i++) strobe(vecs[0].dins[i], 3'(i));
`ifdef DEMUX8_PARITY_EN
    strobe(~^8'h4D, 3'd0);
`endif
    @(negedge clk);
    chk("ovr_before", {31'd0, ovr}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) strobe(1'b0, 3'(i));
    @(negedge clk);
    chk("ovr_q_hold",  {24'd0, q},       32'h4D);
    chk("ovr_valid",   {31'd0, q_valid}, 32'd1);
    chk("ovr_set",     {31'd0, ovr},     32'd1);
    @(posedge clk); #1;
    q_ready = 1'b1;
    strobe(1'b1, 3'd0);
    chk("hs_fall", {31'd0, q_valid}, 32'd0);
    sb_q.push_back({8'h01, 1'b0});
    for (int s = 1; s < 8; s++) strobe(1'b0, 3'(s));
`ifdef DEMUX8_PARITY_EN
    strobe(~^8'h01, 3'd0);
`endif
    chk_valid_pulse("hs_word");
    chk("ovr_sticky", {31'd0, ovr}, 32'd1);

    // Timeout: 3 bits then idle; one tout pulse, q untouched.
    set_mode(1'b0);
    for (int s = 0; s < 3; s++) strobe(1'b1, 3'(s));
    tout_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (tout === 1'b1) tout_cnt++;
    end
    chk("tout_pulses", tout_cnt, 32'd1);
    chk("tout_q_keep", {24'd0, q},       32'h01);
    chk("tout_valid",  {31'd0, q_valid}, 32'd0);
    @(posedge clk); #1;
    vt = '{mode: 1'b0, sels: {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, dins: 8'h96, exp: 8'h96};
    run_word(vt, "after_tout");

    // Asynchronous reset mid-word.
    for (int s = 0; s < 3; s++) strobe(1'b1, 3'(s));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",     {24'd0, q},       32'h0);
    chk("mid_rst_valid", {31'd0, q_valid}, 32'h0);
    chk("mid_rst_ovr",   {31'd0, ovr},     32'h0);
    chk("mid_rst_tout",  {31'd0, tout},    32'h0);
    chk("mid_rst_perr",  {31'd0, q_perr},  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_word(vecs[3], "after_rst");

`ifdef DEMUX8_PARITY_EN
    // Parity: good then bad parity bit over 8'h4D.
    set_mode(1'b0);
    sb_q.push_back({8'h4D, 1'b0});
    for (int i = 0; i < 8; i++) strobe(vecs[0].dins[i], 3'(i));
    strobe(1'b1, 3'd6);
    chk_valid_pulse("par_good");
    set_mode(1'b0);
    sb_q.push_back({8'h4D, 1'b1});
    for (int i = 0; i < 8; i++) strobe(vecs[0].dins[i], 3'(i));
    strobe(1'b0, 3'd6);
    chk_valid_pulse("par_bad");
`endif

    repeat (2) @(posedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
